// File: rtl/conv_row_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// conv_row_scheduler_pkg
// Shared definitions for the row scheduler and its bank ring:
//   - one-hot FSM state encoding (5 states)
//   - bank index width, ring depth, resident-row counter width
//   - Bank_Sel field offsets and a helper that builds the 3-bank window select
// -----------------------------------------------------------------------------
package conv_row_scheduler_pkg;

    localparam int BANK_W    = 2;
    localparam int ROW_BANKS = 4;
    // Resident-row counter has to represent 0..ROW_BANKS inclusive.
    localparam int VCNT_W    = 3;

    // Bank_Sel layout: top row slot, middle row slot, bottom row slot.
    localparam int SEL_TOP_LSB = 0;
    localparam int SEL_MID_LSB = 2;
    localparam int SEL_BOT_LSB = 4;
    localparam int SEL_W       = 6;

    localparam int STATE_W = 5;

    // ST_FIRE is the first cycle of the wait phase: it is the cycle in which
    // Row_Compute_Sign is high. It waits for Row_Done exactly like ST_WAIT_ROW.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 5'b00001,
        ST_ISSUE    = 5'b00010,
        ST_FIRE     = 5'b00100,
        ST_WAIT_ROW = 5'b01000,
        ST_DONE     = 5'b10000
    } state_e;

    // Window select for three consecutive rows starting at the oldest bank.
    // Bank arithmetic wraps naturally in BANK_W bits.
    function automatic logic [SEL_W-1:0] make_bank_sel(input logic [BANK_W-1:0] head);
        logic [SEL_W-1:0] sel;
        sel = '0;
        sel[SEL_TOP_LSB +: BANK_W] = head;
        sel[SEL_MID_LSB +: BANK_W] = head + BANK_W'(1);
        sel[SEL_BOT_LSB +: BANK_W] = head + BANK_W'(2);
        return sel;
    endfunction

endpackage

// File: rtl/conv_row_scheduler_bank_ring_ctrl.sv
// -----------------------------------------------------------------------------
// bank_ring_ctrl
// Bookkeeping for the circular row buffer: the oldest resident bank (head) and
// the number of resident, unconsumed rows.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : one row finished loading into wr_bank_o
//   pop_i        : oldest row retired (head advances)
//   clear_i      : empty the ring and return head to bank 0 (has priority)
//   wr_bank_o    : bank that receives the next loaded row
//   head_o       : oldest resident bank
//   full_o       : every bank holds an unconsumed row
//   ge3_o        : at least three rows resident
// -----------------------------------------------------------------------------
module bank_ring_ctrl
    import conv_row_scheduler_pkg::*;
#(
    parameter int NUM_BANKS = ROW_BANKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              clear_i,
    output logic [BANK_W-1:0] wr_bank_o,
    output logic [BANK_W-1:0] head_o,
    output logic              full_o,
    output logic              ge3_o
);

    logic [BANK_W-1:0] head_q, head_d;
    logic [VCNT_W-1:0] valid_cnt_q, valid_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            valid_cnt_q <= '0;
        end else begin
            head_q      <= head_d;
            valid_cnt_q <= valid_cnt_d;
        end
    end

    // A push and a pop in the same cycle leave the count unchanged while the
    // head still moves on, so the next write bank follows the new head.
    always_comb begin
        head_d      = head_q;
        valid_cnt_d = valid_cnt_q;
        if (clear_i) begin
            head_d      = '0;
            valid_cnt_d = '0;
        end else begin
            if (pop_i) begin
                head_d = head_q + BANK_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   valid_cnt_d = valid_cnt_q + VCNT_W'(1);
                2'b01:   valid_cnt_d = valid_cnt_q - VCNT_W'(1);
                default: valid_cnt_d = valid_cnt_q;
            endcase
        end
    end

    assign wr_bank_o = head_q + valid_cnt_q[BANK_W-1:0];
    assign head_o    = head_q;
    assign full_o    = (valid_cnt_q == VCNT_W'(NUM_BANKS));
    assign ge3_o     = (valid_cnt_q >= VCNT_W'(3));

endmodule

// File: rtl/conv_row_scheduler.sv
// -----------------------------------------------------------------------------
// conv_row_scheduler
// Row-level controller between the feature-map loader and the 3x3 window
// generator. Grants ring banks to the loader, fires Row_Compute_Sign when three
// padded rows are resident, presents the three banks for the window, and
// retires the oldest bank after each output row.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   Start                  : begin a layer (accepted only in IDLE)
//   Row_Num_After_Padding  : padded rows per layer R (>=3), sampled at Start
//   Wr_Allow / Wr_Bank     : loader may write the next row into Wr_Bank
//   Wr_Row_Done            : loader finished a row (counted only with Wr_Allow)
//   Row_Compute_Sign       : one-cycle pulse, three rows ready in Bank_Sel
//   Bank_Sel               : {bottom, middle, top} bank indices, 2 bits each
//   Row_Done               : window generator finished one output row
//   Layer_Done             : one-cycle pulse after the last output row
//   Busy                   : FSM not in IDLE
//   Dbg_State              : one-hot FSM state
// Handshake: Wr_Row_Done is accepted on a rising clk edge only while Wr_Allow
// is high; Row_Done is accepted only while waiting for an output row (FIRE or
// WAIT_ROW). Pulses outside those windows are dropped without side effects.
// -----------------------------------------------------------------------------
module conv_row_scheduler
    import conv_row_scheduler_pkg::*;
#(
    parameter int ROW_BANKS          = 4,
    parameter int WIDTH_FEATURE_SIZE = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          Start,
    input  logic [WIDTH_FEATURE_SIZE-1:0] Row_Num_After_Padding,
    output logic                          Wr_Allow,
    output logic [BANK_W-1:0]             Wr_Bank,
    input  logic                          Wr_Row_Done,
    output logic                          Row_Compute_Sign,
    output logic [SEL_W-1:0]              Bank_Sel,
    input  logic                          Row_Done,
    output logic                          Layer_Done,
    output logic                          Busy,
    output logic [STATE_W-1:0]            Dbg_State
);

    localparam int W = WIDTH_FEATURE_SIZE;

    state_e            state_q, state_d;
    logic [W-1:0]      r_q, r_d;
    logic [W-1:0]      load_cnt_q, load_cnt_d;
    logic [W-1:0]      out_cnt_q, out_cnt_d;
    logic [SEL_W-1:0]  bank_sel_q, bank_sel_d;

    logic              loader_active;
    logic              wait_phase;
    logic              wr_allow;
    logic              push;
    logic              row_done_acc;
    logic              last_row;
    logic              pop;
    logic              start_acc;
    logic              ring_clear;
    logic              issue_fire;
    logic [W-1:0]      out_cnt_inc;
    logic [BANK_W-1:0] ring_wr_bank;
    logic [BANK_W-1:0] ring_head;
    logic              ring_full;
    logic              ring_ge3;

    bank_ring_ctrl #(
        .NUM_BANKS (ROW_BANKS)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .pop_i     (pop),
        .clear_i   (ring_clear),
        .wr_bank_o (ring_wr_bank),
        .head_o    (ring_head),
        .full_o    (ring_full),
        .ge3_o     (ring_ge3)
    );

    // ---------------- handshake decode (registers only) ----------------
    assign loader_active = (state_q == ST_ISSUE) || (state_q == ST_FIRE) ||
                           (state_q == ST_WAIT_ROW);
    assign wait_phase    = (state_q == ST_FIRE) || (state_q == ST_WAIT_ROW);
    assign wr_allow      = loader_active && !ring_full && (load_cnt_q < r_q);
    assign push          = Wr_Row_Done && wr_allow;
    assign row_done_acc  = Row_Done && wait_phase;
    assign out_cnt_inc   = out_cnt_q + W'(1);
    assign last_row      = row_done_acc && (out_cnt_inc == (r_q - W'(2)));
    // The final output row leaves the ring to be wiped by DONE.
    assign pop           = row_done_acc && !last_row;
    assign start_acc     = (state_q == ST_IDLE) && Start;
    assign ring_clear    = start_acc || (state_q == ST_DONE);
    assign issue_fire    = (state_q == ST_ISSUE) && ring_ge3;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (Start) state_d = ST_ISSUE;
            ST_ISSUE: if (ring_ge3) state_d = ST_FIRE;
            ST_FIRE, ST_WAIT_ROW: begin
                if (row_done_acc) begin
                    state_d = last_row ? ST_DONE : ST_ISSUE;
                end else begin
                    state_d = ST_WAIT_ROW;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        Busy             = (state_q != ST_IDLE);
        Row_Compute_Sign = (state_q == ST_FIRE);
        Layer_Done       = (state_q == ST_DONE);
        Wr_Allow         = wr_allow;
        Wr_Bank          = ring_wr_bank;
        Bank_Sel         = bank_sel_q;
        Dbg_State        = state_q;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q        <= '0;
            load_cnt_q <= '0;
            out_cnt_q  <= '0;
            bank_sel_q <= '0;
        end else begin
            r_q        <= r_d;
            load_cnt_q <= load_cnt_d;
            out_cnt_q  <= out_cnt_d;
            bank_sel_q <= bank_sel_d;
        end
    end

    always_comb begin
        r_d        = r_q;
        load_cnt_d = load_cnt_q;
        out_cnt_d  = out_cnt_q;
        bank_sel_d = bank_sel_q;
        if (start_acc) begin
            r_d = Row_Num_After_Padding;
        end
        if (ring_clear) begin
            load_cnt_d = '0;
            out_cnt_d  = '0;
        end else begin
            if (push) begin
                load_cnt_d = load_cnt_q + W'(1);
            end
            if (row_done_acc) begin
                out_cnt_d = out_cnt_inc;
            end
        end
        // Bank_Sel stays put from the pulse until the next issue.
        if (issue_fire) begin
            bank_sel_d = make_bank_sel(ring_head);
        end
    end

endmodule
